// File: rtl/mem_bus_if_if.sv
// Wishbone-style data bus between the mem-stage bus interface (master)
// and the external memory system (slave).
interface mem_bus_if_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          we;
  logic [SW-1:0] sel;
  logic          stb;
  logic          cyc;
  logic          ack;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack
  );
endinterface

// File: rtl/mem_bus_if.sv
// Data-side bus master for the mem stage: turns a one-cycle memory request
// into a Wishbone classic transaction and stalls the pipeline until it ends.
module mem_bus_if #(
  parameter int unsigned STALL_IDX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  mem_bus_if_if.master wb
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [2:0]  STALL_BIT = 3'(STALL_IDX);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          stb_q, stb_d;
  logic          cyc_q, cyc_d;
  logic [DW-1:0] rd_buf_q, rd_buf_d;

  logic mem_stall;
  logic unused_stall;

  // Only the mem-stage bit of the stall vector matters here.
  assign mem_stall    = stall_i[STALL_BIT];
  assign unused_stall = ^stall_i;

  // Next-state and bus-output computation.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    cyc_d    = cyc_q;
    rd_buf_d = rd_buf_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          adr_d   = cpu_addr_i;
          dat_d   = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = BUSY;
        end else begin
          adr_d = '0;
          dat_d = '0;
          we_d  = 1'b0;
          sel_d = '0;
          stb_d = 1'b0;
          cyc_d = 1'b0;
        end
      end

      BUSY: begin
        // Flush outranks a coincident ack: the returned data is dropped.
        if (flush_i || wb.ack) begin
          adr_d = '0;
          dat_d = '0;
          we_d  = 1'b0;
          sel_d = '0;
          stb_d = 1'b0;
          cyc_d = 1'b0;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            rd_buf_d = we_q ? '0 : wb.dat_r;
            state_d  = mem_stall ? WAIT_STALL : IDLE;
          end
        end
      end

      WAIT_STALL: begin
        adr_d = '0;
        dat_d = '0;
        we_d  = 1'b0;
        sel_d = '0;
        stb_d = 1'b0;
        cyc_d = 1'b0;
        if (!mem_stall || flush_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        adr_d   = '0;
        dat_d   = '0;
        we_d    = 1'b0;
        sel_d   = '0;
        stb_d   = 1'b0;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  assign wb.adr   = adr_q;
  assign wb.dat_w = dat_q;
  assign wb.we    = we_q;
  assign wb.sel   = sel_q;
  assign wb.stb   = stb_q;
  assign wb.cyc   = cyc_q;

  // Pipeline-facing outputs are combinational so the ack cycle itself
  // releases the stall and presents read data at the capturing edge.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          stallreq_o = cpu_ce_i & ~flush_i;
        end
        BUSY: begin
          stallreq_o = ~wb.ack & ~flush_i;
          if (wb.ack && !we_q) begin
            cpu_data_o = wb.dat_r;
          end
        end
        WAIT_STALL: begin
          cpu_data_o = rd_buf_q;
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: directed scenarios plus randomized
// transactions checked against a cycle-timeline model of one bus access.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  mem_bus_if_if bus ();

  mem_bus_if #(.STALL_IDX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random controller stall vector with the mem-stage bit forced.
  task automatic set_stall(input logic mem_bit);
    logic [5:0] s;
    s       = 6'($urandom);
    s[4]    = mem_bit;
    stall_i = s;
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_cyc"}, 32'(bus.cyc), 32'd0);
    chk({tag, "_stb"}, 32'(bus.stb), 32'd0);
    chk({tag, "_adr"}, bus.adr, 32'd0);
    chk({tag, "_datw"}, bus.dat_w, 32'd0);
    chk({tag, "_sel"}, 32'(bus.sel), 32'd0);
    chk({tag, "_we"}, 32'(bus.we), 32'd0);
  endtask

  // One complete access: request cycle, wait_n unacked BUSY cycles, the ack
  // cycle, hold_n cycles held by downstream stall, then one idle cycle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic we,
                         input int wait_n, input logic [31:0] rdata,
                         input int hold_n);
    logic [31:0] exp_rd;
    exp_rd     = we ? 32'd0 : rdata;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    cpu_sel_i  = sel;
    cpu_we_i   = we;
    flush_i    = 1'b0;
    bus.ack    = 1'b0;
    set_stall(1'b0);
    #2;
    chk("req_stallreq", 32'(stallreq_o), 32'd1);
    chk("req_cyc", 32'(bus.cyc), 32'd0);
    chk("req_cpudata", cpu_data_o, 32'd0);
    tick();
    for (int k = 0; k <= wait_n; k++) begin
      bus.ack    = (k == wait_n);
      bus.dat_r  = (k == wait_n) ? rdata : $urandom;
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      set_stall((k == wait_n) && (hold_n > 0));
      #2;
      chk("busy_cyc", 32'(bus.cyc), 32'd1);
      chk("busy_stb", 32'(bus.stb), 32'd1);
      chk("busy_adr", bus.adr, addr);
      chk("busy_datw", bus.dat_w, wdata);
      chk("busy_sel", 32'(bus.sel), 32'(sel));
      chk("busy_we", 32'(bus.we), 32'(we));
      chk("busy_stallreq", 32'(stallreq_o), (k == wait_n) ? 32'd0 : 32'd1);
      chk("busy_cpudata", cpu_data_o, (k == wait_n) ? exp_rd : 32'd0);
      tick();
    end
    bus.ack   = 1'b0;
    bus.dat_r = $urandom;
    for (int j = 0; j < hold_n; j++) begin
      set_stall(j < hold_n - 1);
      cpu_ce_i   = 1'b1;
      cpu_addr_i = $urandom;
      #2;
      chk("hold_cyc", 32'(bus.cyc), 32'd0);
      chk("hold_stallreq", 32'(stallreq_o), 32'd0);
      chk("hold_cpudata", cpu_data_o, exp_rd);
      tick();
    end
    cpu_ce_i = 1'b0;
    set_stall(1'b0);
    #2;
    chk_bus_idle("post");
    chk("post_stallreq", 32'(stallreq_o), 32'd0);
    chk("post_cpudata", cpu_data_o, 32'd0);
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    stall_i    = 6'd0;
    flush_i    = 1'b0;
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h0000_1000;
    cpu_we_i   = 1'b0;
    cpu_sel_i  = 4'hF;
    cpu_data_i = 32'h1111_2222;
    bus.ack    = 1'b0;
    bus.dat_r  = 32'hFFFF_FFFF;
    #3;
    chk_bus_idle("rst");
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_cpudata", cpu_data_o, 32'd0);
    cpu_ce_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();

    // Zero-wait read.
    run_txn(32'h0000_0104, 32'h0, 4'b1111, 1'b0, 0, 32'hDEAD_BEEF, 0);
    // Three-wait write.
    run_txn(32'h0000_0010, 32'h1234_5678, 4'b0011, 1'b1, 3, 32'hCAFE_F00D, 0);
    // Read held three cycles by downstream stall.
    run_txn(32'h0000_0020, 32'h0, 4'b1111, 1'b0, 1, 32'hA5A5_0001, 3);

    // Flush in the second BUSY cycle, ack one cycle later.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0200; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
    set_stall(1'b0);
    #2;
    chk("fl_req_stallreq", 32'(stallreq_o), 32'd1);
    tick();
    bus.ack = 1'b0;
    #2;
    chk("fl_busy1_cyc", 32'(bus.cyc), 32'd1);
    chk("fl_busy1_stallreq", 32'(stallreq_o), 32'd1);
    tick();
    flush_i = 1'b1;
    #2;
    chk("fl_busy2_cyc", 32'(bus.cyc), 32'd1);
    chk("fl_busy2_stallreq", 32'(stallreq_o), 32'd0);
    tick();
    flush_i = 1'b0; cpu_ce_i = 1'b0; bus.ack = 1'b1; bus.dat_r = 32'h0BAD_0BAD;
    #2;
    chk_bus_idle("fl_after");
    chk("fl_after_stallreq", 32'(stallreq_o), 32'd0);
    chk("fl_after_cpudata", cpu_data_o, 32'd0);
    tick();
    bus.ack = 1'b0;
    #2;
    chk("fl_after2_cyc", 32'(bus.cyc), 32'd0);
    tick();

    // Ack and flush together while downstream stall is asserted.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0300; cpu_we_i = 1'b0;
    tick();
    bus.ack = 1'b1; flush_i = 1'b1; bus.dat_r = 32'h5A5A_1234;
    set_stall(1'b1);
    #2;
    chk("af_stallreq", 32'(stallreq_o), 32'd0);
    tick();
    bus.ack = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0;
    #2;
    chk("af_next_cpudata", cpu_data_o, 32'd0);
    chk("af_next_stallreq", 32'(stallreq_o), 32'd0);
    chk("af_next_cyc", 32'(bus.cyc), 32'd0);
    tick();
    set_stall(1'b0);
    #2;
    chk("af_idle_cpudata", cpu_data_o, 32'd0);
    tick();

    // Asynchronous reset in the middle of a BUSY write.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0040; cpu_data_i = 32'h7777_8888;
    cpu_we_i = 1'b1; cpu_sel_i = 4'b1100;
    tick();
    bus.ack = 1'b0;
    #2;
    chk("ar_busy_cyc", 32'(bus.cyc), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_bus_idle("ar");
    chk("ar_stallreq", 32'(stallreq_o), 32'd0);
    chk("ar_cpudata", cpu_data_o, 32'd0);
    cpu_ce_i = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    run_txn(32'h0000_0044, 32'h9999_AAAA, 4'b0101, 1'b1, 2, 32'h0, 0);

    // Randomized accesses.
    for (int n = 0; n < 24; n++) begin
      run_txn($urandom, $urandom, 4'($urandom), 1'($urandom),
              int'($urandom_range(0, 4)), $urandom | 32'h1,
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
